jpeg_dequant_pipe: RTL and testbench
====================================

Name: jpeg_dequant_pipe

Overview:
- Inverse of the encoder's quantizer/divider path. Sits at the front of the JPEG decode datapath, after entropy decode and before the inverse DCT.
- Function: takes signed quantized coefficients in zig-zag order, multiplies each by its 8-bit quantization-table entry, and emits saturated 16-bit signed DCT coefficients.
- Datapath: 3-stage pipeline with a per-stage sign pipe (spipe) and valid pipe. Ready/valid handshake on both sides with full-pipeline stall.

Parameters:
- CW, 12, input coefficient width (signed).
- QW, 8, quantization entry width (unsigned).
- OW, 16, output coefficient width (signed).
- NCOEF, 64, coefficients per block; the position counter width is log2(NCOEF).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  CW  quantized coefficient, two's complement.
- din_first  in  1  marks the first coefficient of a block; forces position 0.
- din_valid  in  1  input valid.
- din_ready  out  1  input ready.
- qt_we  in  1  quant-table write enable.
- qt_addr  in  6  quant-table write address (zig-zag index).
- qt_data  in  QW  quant-table write data.
- dout  out  OW  dequantized coefficient.
- dout_pos  out  6  zig-zag index of dout.
- dout_last  out  1  high with the coefficient at index NCOEF-1.
- dout_valid  out  1  output valid.
- dout_ready  in  1  output ready.

Behaviour:
- Reset (rst=1 at a clock edge): vpipe[2:0]=0, spipe[2:0]=0, pos=0, dout=0, dout_pos=0, dout_last=0, dout_valid=0, all 64 table entries=1 (identity). Reset mid-block discards all in-flight data; there are no partial outputs afterwards.
- Stall:
  - stall = dout_valid & ~dout_ready; din_ready = ~stall (combinational).
  - While stalled, every pipeline register holds.
  - Accept = din_valid & din_ready.
- Position counter:
  - On accept, the sample's index is idx = din_first ? 0 : pos, and pos <= idx+1, wrapping 63->0.
  - din_first at a nonzero pos truncates the current block silently; dout_last is not emitted for the truncated block.
- Stage 1, on accept or a bubble advance:
  - mag1 = |din| as a CW-bit unsigned value; -2048 gives 2048.
  - spipe[0] = din[CW-1] & (din!=0).
  - q1 = table[idx], using the registered table value before any same-cycle write.
  - pos1 = idx; vpipe[0] = accept.
- Stage 2: prod2 = mag1*q1, unsigned, CW+QW=20 bits. spipe[1], pos and valid advance with the data.
- Stage 3:
  - sat = (prod2 > 2^(OW-1)-1) ? 32767 : prod2[14:0].
  - dout = spipe[2] ? -sat : sat.
  - dout_pos = pos; dout_last = (pos==63); dout_valid = vpipe[2].
- Latency: exactly 3 cycles from accept to dout_valid when there is no stall. Throughput is 1 per cycle.
- When not stalled, an empty stage passes a bubble (valid=0); data registers may update freely under valid=0.
- Quant table:
  - A write on qt_we takes effect at the next edge and is ignored during rst.
  - Read and write to the same address in the same cycle: the sample uses the old value.
  - Writes are accepted during a stall.
  - q=0 yields dout=0 with spipe ignored; -0 is never produced.
- Saturation is symmetric: the most negative output is -32767, never -32768.
- dout_last, dout_pos and dout are all registered; there are no combinational paths except din_ready.

Decomposition:
- Package jpeg_dequant_pkg:
  - CW/QW/OW/NCOEF defaults.
  - typedef coef_t (signed CW), qent_t (QW), dct_t (signed OW), zz_idx_t (6-bit).
  - Constant SAT_MAX = 32767.
  - Constant QT_RESET = 1.
- Sub-module jpeg_dequant_qtable: 64xQW register file.
  - One synchronous write port and one asynchronous read port.
  - Reset to QT_RESET.
  - The pipeline registers q1 from the read port.

Test Plan:
- Reset, then stream 64 samples din=1, all q=1, dout_ready=1 -> dout=1 for each, dout_pos 0..63 starting exactly 3 cycles after the first accept, dout_last only at pos 63, then pos wraps to 0.
- Load q[5]=200, send din=-2048 at index 5 -> dout=-32767 (saturated); send din=100 at index 5 -> dout=20000; send din=-3 -> dout=-600.
- Hold dout_ready=0 for 5 cycles mid-stream -> din_ready=0 starting the same cycle dout_valid=1, dout held stable, no sample lost or duplicated, order preserved after release.
- Write qt_addr=0, qt_data=7 in the same cycle as accepting din=2 at index 0 -> dout=2 (old q=1); next block index 0 with din=2 -> dout=14.
- Assert rst with 3 samples in flight and pos=10 -> dout_valid=0 the next cycle, no stale outputs appear, table back to 1, the next accept gets dout_pos=0.
- din_first=1 at pos=30 with din=-5, q[0]=16 -> dout=-80, dout_pos=0; the preceding block produces no dout_last; q=0 with din=-9 -> dout=0.

Source files
------------

// File: rtl/jpeg_dequant_pkg.sv
// Shared types and constants for the JPEG dequantizer pipeline.
package jpeg_dequant_pkg;

   localparam int unsigned CW    = 12;
   localparam int unsigned QW    = 8;
   localparam int unsigned OW    = 16;
   localparam int unsigned NCOEF = 64;
   localparam int unsigned PW    = $clog2(NCOEF);
   localparam int unsigned PRW   = CW + QW;

   typedef logic signed [CW-1:0]  coef_t;
   typedef logic        [QW-1:0]  qent_t;
   typedef logic signed [OW-1:0]  dct_t;
   typedef logic        [PW-1:0]  zz_idx_t;
   typedef logic        [CW-1:0]  mag_t;
   typedef logic        [PRW-1:0] prod_t;
   typedef logic        [OW-2:0]  sat_t;

   localparam dct_t    SAT_MAX  = 16'sd32767;
   localparam qent_t   QT_RESET = 8'd1;
   localparam zz_idx_t POS_LAST = zz_idx_t'(NCOEF - 1);

   // Magnitude as an unsigned CW-bit value; the most negative input maps to 2^(CW-1).
   function automatic mag_t abs_coef(input coef_t v);
      mag_t u;
      u = mag_t'(v);
      return v[CW-1] ? (~u + {{(CW-1){1'b0}}, 1'b1}) : u;
   endfunction

   // Clamp an unsigned product to the largest positive output magnitude.
   function automatic sat_t sat_prod(input prod_t p);
      prod_t lim;
      lim = prod_t'(SAT_MAX);
      return (p > lim) ? SAT_MAX[OW-2:0] : p[OW-2:0];
   endfunction

endpackage

// File: rtl/jpeg_dequant_qtable.sv
// 64-entry quantization table: one synchronous write port, one asynchronous read port.
module jpeg_dequant_qtable
   import jpeg_dequant_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst,
   input  logic    i_we,
   input  zz_idx_t i_waddr,
   input  qent_t   i_wdata,
   input  zz_idx_t i_raddr,
   output qent_t   o_rdata
);

   qent_t r_mem [NCOEF];

   // Table storage: reset to identity, writes land on the next edge and are dropped during reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(NCOEF); i++) begin
            r_mem[i] <= QT_RESET;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read returns the stored value, so a same-cycle write is not visible yet.
   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jpeg_dequant_pipe.sv
// Three-stage dequantizer: |coef| * q, saturate, re-apply sign. Full-pipeline stall on backpressure.
module jpeg_dequant_pipe
   import jpeg_dequant_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst,
   input  coef_t   i_din,
   input  logic    i_din_first,
   input  logic    i_din_valid,
   output logic    o_din_ready,
   input  logic    i_qt_we,
   input  zz_idx_t i_qt_addr,
   input  qent_t   i_qt_data,
   output dct_t    o_dout,
   output zz_idx_t o_dout_pos,
   output logic    o_dout_last,
   output logic    o_dout_valid,
   input  logic    i_dout_ready
);

   logic    w_stall;
   logic    w_accept;
   zz_idx_t w_idx;
   zz_idx_t w_pos_next;
   qent_t   w_q;
   sat_t    w_sat;
   dct_t    w_dout_next;

   zz_idx_t r_pos;
   logic [2:0] r_vpipe;
   // Sign travels with stages 1 and 2; at stage 3 it is folded into dout itself.
   logic [1:0] r_spipe;

   mag_t    r_mag1;
   qent_t   r_q1;
   zz_idx_t r_pos1;

   prod_t   r_prod2;
   zz_idx_t r_pos2;

   dct_t    r_dout;
   zz_idx_t r_dout_pos;
   logic    r_dout_last;

   assign w_stall     = r_vpipe[2] & ~i_dout_ready;
   assign o_din_ready = ~w_stall;
   assign w_accept    = i_din_valid & ~w_stall;

   assign w_idx      = i_din_first ? '0 : r_pos;
   assign w_pos_next = (w_idx == POS_LAST) ? '0 : w_idx + zz_idx_t'(1);

   jpeg_dequant_qtable u_qtable (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (i_qt_we),
      .i_waddr (i_qt_addr),
      .i_wdata (i_qt_data),
      .i_raddr (w_idx),
      .o_rdata (w_q)
   );

   // Stage-3 value: saturated magnitude with sign; a zero magnitude stays +0.
   always_comb begin
      w_sat       = sat_prod(r_prod2);
      w_dout_next = dct_t'({1'b0, w_sat});
      if (r_spipe[1]) begin
         w_dout_next = -dct_t'({1'b0, w_sat});
      end
   end

   // Zig-zag position counter, advanced only by accepted samples.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pos <= '0;
      end else if (w_accept) begin
         r_pos <= w_pos_next;
      end
   end

   // Valid and sign pipes: bubbles enter when nothing is accepted, everything holds on stall.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vpipe <= '0;
         r_spipe <= '0;
      end else if (!w_stall) begin
         r_vpipe <= {r_vpipe[1:0], w_accept};
         r_spipe <= {r_spipe[0], i_din[CW-1] & (i_din != '0)};
      end
   end

   // Stage 1: magnitude, table lookup and index capture.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mag1 <= '0;
         r_q1   <= '0;
         r_pos1 <= '0;
      end else if (!w_stall) begin
         r_mag1 <= abs_coef(i_din);
         r_q1   <= w_q;
         r_pos1 <= w_idx;
      end
   end

   // Stage 2: unsigned multiply at full product width.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prod2 <= '0;
         r_pos2  <= '0;
      end else if (!w_stall) begin
         r_prod2 <= prod_t'(r_mag1) * prod_t'(r_q1);
         r_pos2  <= r_pos1;
      end
   end

   // Stage 3: registered output coefficient, position and end-of-block flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dout      <= '0;
         r_dout_pos  <= '0;
         r_dout_last <= 1'b0;
      end else if (!w_stall) begin
         r_dout      <= w_dout_next;
         r_dout_pos  <= r_pos2;
         r_dout_last <= (r_pos2 == POS_LAST);
      end
   end

   assign o_dout       = r_dout;
   assign o_dout_pos   = r_dout_pos;
   assign o_dout_last  = r_dout_last;
   assign o_dout_valid = r_vpipe[2];

endmodule

// File: tb/tb_jpeg_dequant_pipe.sv
// Directed bench for jpeg_dequant_pipe with hand-computed expected values.
module tb_jpeg_dequant_pipe;
   import jpeg_dequant_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] din;
   logic        din_first;
   logic        din_valid;
   logic        din_ready;
   logic        qt_we;
   logic [5:0]  qt_addr;
   logic [7:0]  qt_data;
   logic signed [15:0] dout;
   logic [5:0]  dout_pos;
   logic        dout_last;
   logic        dout_valid;
   logic        dout_ready;

   int n_cmp  = 0;
   int n_err  = 0;
   int n_last = 0;

   always #5 clk = ~clk;

   jpeg_dequant_pipe u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_din        (din),
      .i_din_first  (din_first),
      .i_din_valid  (din_valid),
      .o_din_ready  (din_ready),
      .i_qt_we      (qt_we),
      .i_qt_addr    (qt_addr),
      .i_qt_data    (qt_data),
      .o_dout       (dout),
      .o_dout_pos   (dout_pos),
      .o_dout_last  (dout_last),
      .o_dout_valid (dout_valid),
      .i_dout_ready (dout_ready)
   );

   // Count delivered end-of-block markers.
   always @(posedge clk) begin
      if (!rst && dout_valid && dout_ready && dout_last) n_last++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic qwrite(input int addr, input int data);
      qt_we   = 1'b1;
      qt_addr = 6'(addr);
      qt_data = 8'(data);
      tick();
      qt_we   = 1'b0;
   endtask

   // Feed zero samples from a fresh block start so the next index is n, then drain.
   task automatic seek(input int n);
      for (int i = 0; i < n; i++) begin
         din_valid = 1'b1;
         din       = '0;
         din_first = (i == 0);
         tick();
      end
      din_valid = 1'b0;
      din_first = 1'b0;
      repeat (3) tick();
   endtask

   // One isolated sample; output is checked when it reaches the stage-3 register.
   task automatic xfer(input string tag, input int d, input logic first, input int exp_d,
                       input int exp_pos, input logic exp_last);
      din       = 12'(d);
      din_first = first;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      din_first = 1'b0;
      tick();
      tick();
      chk({tag, "_valid"}, dout_valid, 1);
      chk({tag, "_dout"},  dout, exp_d);
      chk({tag, "_pos"},   dout_pos, exp_pos);
      chk({tag, "_last"},  dout_last, exp_last);
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      din        = '0;
      din_first  = 1'b0;
      din_valid  = 1'b0;
      qt_we      = 1'b0;
      qt_addr    = '0;
      qt_data    = '0;
      dout_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_valid", dout_valid, 0);
      chk("rst_dout",  dout, 0);
      chk("rst_pos",   dout_pos, 0);
      chk("rst_last",  dout_last, 0);
      chk("rst_ready", din_ready, 1);

      // Full block of ones through identity table, back to back
      for (int k = 0; k < 66; k++) begin
         if (k < 64) begin
            din_valid = 1'b1;
            din       = 12'd1;
            din_first = (k == 0);
         end else begin
            din_valid = 1'b0;
            din_first = 1'b0;
         end
         tick();
         if (k >= 2) begin
            chk("strm_valid", dout_valid, 1);
            chk("strm_dout",  dout, 1);
            chk("strm_pos",   dout_pos, k - 2);
            chk("strm_last",  dout_last, (k - 2) == 63);
         end else begin
            chk("strm_lat", dout_valid, 0);
         end
      end
      din_valid = 1'b0;
      tick();
      chk("strm_drain", dout_valid, 0);
      chk("strm_nlast", n_last, 1);
      xfer("wrap", 7, 1'b0, 7, 0, 1'b0);

      // Saturation and scaling at index 5 with q=200
      qwrite(5, 200);
      seek(5);
      xfer("sat_neg", -2048, 1'b0, -32767, 5, 1'b0);
      seek(5);
      xfer("sat_pos", 2047, 1'b0, 32767, 5, 1'b0);
      seek(5);
      xfer("mul_pos", 100, 1'b0, 20000, 5, 1'b0);
      seek(5);
      xfer("mul_neg", -3, 1'b0, -600, 5, 1'b0);

      // Backpressure: samples 1..8 at indices 10..17
      seek(10);
      din_valid = 1'b1;
      din       = 12'd1;
      tick();
      din       = 12'd2;
      tick();
      dout_ready = 1'b0;
      din        = 12'd3;
      tick();
      chk("stl_valid0", dout_valid, 1);
      chk("stl_ready0", din_ready, 0);
      chk("stl_dout0",  dout, 1);
      din = 12'd4;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("stl_hold_v",   dout_valid, 1);
         chk("stl_hold_d",   dout, 1);
         chk("stl_hold_pos", dout_pos, 10);
         chk("stl_hold_rdy", din_ready, 0);
      end
      dout_ready = 1'b1;
      #1;
      chk("stl_release", din_ready, 1);
      for (int m = 0; m < 7; m++) begin
         if (m <= 4) begin
            din_valid = 1'b1;
            din       = 12'(4 + m);
         end else begin
            din_valid = 1'b0;
         end
         tick();
         chk("stl_out_v",   dout_valid, 1);
         chk("stl_out_d",   dout, 2 + m);
         chk("stl_out_pos", dout_pos, 11 + m);
      end
      din_valid = 1'b0;
      tick();
      chk("stl_empty", dout_valid, 0);

      // Table write in the same cycle as a read of that entry
      din       = 12'd2;
      din_first = 1'b1;
      din_valid = 1'b1;
      qt_we     = 1'b1;
      qt_addr   = 6'd0;
      qt_data   = 8'd7;
      tick();
      qt_we     = 1'b0;
      din_valid = 1'b0;
      din_first = 1'b0;
      tick();
      tick();
      chk("wr_old_v", dout_valid, 1);
      chk("wr_old_d", dout, 2);
      chk("wr_old_p", dout_pos, 0);
      tick();
      xfer("wr_new", 2, 1'b1, 14, 0, 1'b0);

      // Reset with three samples in flight; table write during reset is dropped
      seek(7);
      din_valid = 1'b1;
      din       = 12'd5;
      repeat (3) tick();
      din_valid = 1'b0;
      rst       = 1'b1;
      qt_we     = 1'b1;
      qt_addr   = 6'd5;
      qt_data   = 8'd99;
      tick();
      rst   = 1'b0;
      qt_we = 1'b0;
      chk("mrst_valid", dout_valid, 0);
      chk("mrst_dout",  dout, 0);
      chk("mrst_pos",   dout_pos, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("mrst_stale", dout_valid, 0);
      end
      xfer("mrst_q0", 3, 1'b0, 3, 0, 1'b0);
      seek(5);
      xfer("mrst_q5", 100, 1'b0, 100, 5, 1'b0);

      // Truncated block restarted by din_first, then a zero table entry
      qwrite(0, 16);
      seek(30);
      xfer("trunc", -5, 1'b1, -80, 0, 1'b0);
      qwrite(1, 0);
      xfer("qzero", -9, 1'b0, 0, 1, 1'b0);
      chk("trunc_nlast", n_last, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
